// File: rtl/image_fitness_accumulator.sv
`default_nettype none
// ============================================================================
// image_fitness_accumulator: pipelined per-frame SAD against a target image,
// tracking the best (lowest) frame score.  Rev 1.0
// ============================================================================
module image_fitness_accumulator #(
  parameter int WidthAddressSize  = 8,
  parameter int HeightAddressSize = 8,
  parameter int Resolution        = 8,
  parameter int AccWidth          = WidthAddressSize + HeightAddressSize + Resolution + 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         pixelValid,
  input  logic [3*Resolution-1:0]      pixel,
  input  logic [HeightAddressSize-1:0] pixelLine,
  input  logic [WidthAddressSize-1:0]  pixelColumn,
  output logic                         targetRead,
  output logic [HeightAddressSize-1:0] targetLine,
  output logic [WidthAddressSize-1:0]  targetColumn,
  input  logic [3*Resolution-1:0]      targetPixel,
  input  logic                         clearBest,
  output logic [AccWidth-1:0]          fitness,
  output logic [AccWidth-1:0]          bestFitness,
  output logic                         busy,
  output logic                         done,
  output logic                         improved
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state;
  logic                    accept;
  logic                    last_coord;
  logic                    s1_valid;
  logic                    s1_last;
  logic [3*Resolution-1:0] s1_pixel;
  logic [Resolution-1:0]   chan_diff [3];
  logic [Resolution+1:0]   pixel_sad;
  logic [AccWidth-1:0]     fitness_next;
  logic [AccWidth-1:0]     best_ref;

  function automatic logic [Resolution-1:0] abs_diff(input logic [Resolution-1:0] a,
                                                     input logic [Resolution-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign accept       = pixelValid && (state == ACCUM) && !start;
  assign last_coord   = (&pixelLine) && (&pixelColumn);
  assign targetRead   = accept;
  assign targetLine   = pixelLine;
  assign targetColumn = pixelColumn;
  assign busy         = (state != IDLE);

  // Target data arrives one cycle after the read, lining up with stage 1.
  for (genvar ch = 0; ch < 3; ch++) begin : g_channel
    assign chan_diff[ch] = abs_diff(s1_pixel[ch*Resolution +: Resolution],
                                    targetPixel[ch*Resolution +: Resolution]);
  end

  assign pixel_sad    = {2'b00, chan_diff[0]} + {2'b00, chan_diff[1]} + {2'b00, chan_diff[2]};
  assign fitness_next = fitness + AccWidth'(pixel_sad);
  // A coincident clearBest must not hide an improvement from the finishing frame.
  assign best_ref     = clearBest ? '1 : bestFitness;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fitness     <= '0;
      bestFitness <= '1;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_pixel    <= '0;
      done        <= 1'b0;
      improved    <= 1'b0;
    end else begin
      done     <= 1'b0;
      improved <= 1'b0;
      s1_valid <= accept;
      s1_last  <= accept && last_coord;
      if (accept) begin
        s1_pixel <= pixel;
      end
      if (clearBest) begin
        bestFitness <= '1;
      end
      if (start) begin
        state    <= ACCUM;
        fitness  <= '0;
        s1_valid <= 1'b0;
      end else begin
        if (s1_valid) begin
          fitness <= fitness_next;
        end
        if (s1_valid && s1_last) begin
          state <= IDLE;
          done  <= 1'b1;
          if (fitness_next < best_ref) begin
            bestFitness <= fitness_next;
            improved    <= 1'b1;
          end
        end else if (accept && last_coord) begin
          state <= DRAIN;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_image_fitness_accumulator.sv
`default_nettype none
// ============================================================================
// tb_image_fitness_accumulator: randomized self-checking bench with a
// frame-level SAD reference model.  Rev 1.0
// ============================================================================
module tb_image_fitness_accumulator;

  localparam int W  = 2;
  localparam int H  = 2;
  localparam int R  = 8;
  localparam int AW = W + H + R + 2;
  localparam logic [AW-1:0] ALL_ONES = '1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pixelValid;
  logic [3*R-1:0] pixel;
  logic [H-1:0]  pixelLine;
  logic [W-1:0]  pixelColumn;
  logic          targetRead;
  logic [H-1:0]  targetLine;
  logic [W-1:0]  targetColumn;
  logic [3*R-1:0] targetPixel;
  logic          clearBest;
  logic [AW-1:0] fitness;
  logic [AW-1:0] bestFitness;
  logic          busy;
  logic          done;
  logic          improved;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [23:0]   mem       [16];
  logic [23:0]   frame_pix [16];
  logic [AW-1:0] exp_best;
  logic [AW-1:0] exp_fit;
  logic          exp_imp;

  always #5 clk = ~clk;

  image_fitness_accumulator #(
    .WidthAddressSize (W),
    .HeightAddressSize(H),
    .Resolution       (R),
    .AccWidth         (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pixelValid  (pixelValid),
    .pixel       (pixel),
    .pixelLine   (pixelLine),
    .pixelColumn (pixelColumn),
    .targetRead  (targetRead),
    .targetLine  (targetLine),
    .targetColumn(targetColumn),
    .targetPixel (targetPixel),
    .clearBest   (clearBest),
    .fitness     (fitness),
    .bestFitness (bestFitness),
    .busy        (busy),
    .done        (done),
    .improved    (improved)
  );

  // Target image memory: one-cycle read latency.
  always @(posedge clk) begin
    if (targetRead) targetPixel <= mem[{targetLine, targetColumn}];
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  // Reference: plain sum of per-channel absolute differences over the frame.
  function automatic int model_sum(input int first, input int last);
    int s = 0;
    for (int i = first; i <= last; i++) begin
      int p = int'(frame_pix[i]);
      int t = int'(mem[i]);
      for (int c = 0; c < 3; c++) begin
        int a = (p >> (8 * c)) & 255;
        int b = (t >> (8 * c)) & 255;
        s += (a > b) ? a - b : b - a;
      end
    end
    return s;
  endfunction

  task automatic model_complete(input int sum, input bit cleared);
    exp_fit = AW'(sum);
    if (cleared) exp_best = ALL_ONES;
    exp_imp = (exp_fit < exp_best);
    if (exp_imp) exp_best = exp_fit;
  endtask

  task automatic run_frame(input bit do_start, input bit gap, input bit clr_end, output int lat);
    if (do_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      pixelValid  = 1'b1;
      pixel       = frame_pix[i];
      pixelLine   = H'(i / 4);
      pixelColumn = W'(i % 4);
      @(posedge clk); #1;
      pixelValid = 1'b0;
      pixel      = 24'($urandom);
      if (gap && i != 15) begin
        @(posedge clk); #1;
      end
    end
    clearBest = clr_end;
    lat = 1;
    while (done !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      clearBest = 1'b0;
      lat++;
    end
    clearBest = 1'b0;
  endtask

  task automatic test_reset();
    pixelValid = 1'b1;
    pixelLine  = '1;
    pixelColumn = '1;
    #1;
    checks++; if (targetRead !== 1'b0) begin failures++; $display("FAIL reset_targetRead got=%b want=0", targetRead); end
    @(posedge clk); #1;
    rst = 1'b0;
    pixelValid = 1'b0;
    exp_best = ALL_ONES;
    checks++; if (fitness !== '0) begin failures++; $display("FAIL reset_fitness got=%0d want=0", fitness); end
    checks++; if (bestFitness !== ALL_ONES) begin failures++; $display("FAIL reset_best got=%h want=%h", bestFitness, ALL_ONES); end
    checks++; if ({busy, done, improved} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {busy, done, improved}); end
  endtask

  task automatic test_basic();
    int lat;
    for (int i = 0; i < 16; i++) begin mem[i] = 24'h000000; frame_pix[i] = 24'h102030; end
    run_frame(1'b1, 1'b0, 1'b0, lat);
    model_complete(model_sum(0, 15), 1'b0);
    checks++; if (lat != 2) begin failures++; $display("FAIL basic_latency got=%0d want=2", lat); end
    checks++; if (fitness !== exp_fit) begin failures++; $display("FAIL basic_fitness got=%0d want=%0d", fitness, exp_fit); end
    checks++; if (improved !== exp_imp) begin failures++; $display("FAIL basic_improved got=%b want=%b", improved, exp_imp); end
    checks++; if (bestFitness !== exp_best) begin failures++; $display("FAIL basic_best got=%0d want=%0d", bestFitness, exp_best); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if ({busy, done, improved} !== 3'b000) begin failures++; $display("FAIL basic_after_flags got=%b want=000", {busy, done, improved}); end
    checks++; if (fitness !== exp_fit) begin failures++; $display("FAIL basic_hold got=%0d want=%0d", fitness, exp_fit); end
  endtask

  task automatic test_repeat();
    int lat;
    for (int i = 0; i < 16; i++) begin mem[i] = 24'($urandom); frame_pix[i] = mem[i]; end
    run_frame(1'b1, 1'b0, 1'b0, lat);
    model_complete(model_sum(0, 15), 1'b0);
    checks++; if (fitness !== exp_fit || improved !== exp_imp || bestFitness !== exp_best) begin
      failures++; $display("FAIL repeat_equal got=%0d/%b/%0d want=%0d/%b/%0d", fitness, improved, bestFitness, exp_fit, exp_imp, exp_best);
    end
    mem[0][7:0] = 8'($urandom_range(0, 250));
    for (int i = 0; i < 16; i++) frame_pix[i] = mem[i];
    frame_pix[0][7:0] = mem[0][7:0] + 8'd5;
    run_frame(1'b1, 1'b0, 1'b0, lat);
    model_complete(model_sum(0, 15), 1'b0);
    checks++; if (fitness !== exp_fit || improved !== exp_imp || bestFitness !== exp_best) begin
      failures++; $display("FAIL repeat_plus5 got=%0d/%b/%0d want=%0d/%b/%0d", fitness, improved, bestFitness, exp_fit, exp_imp, exp_best);
    end
  endtask

  task automatic test_underflow();
    int lat;
    mem[15] = 24'hFF00FF;
    frame_pix[15] = 24'h00FF00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pixelValid = 1'b1; pixel = frame_pix[15]; pixelLine = '1; pixelColumn = '1;
    @(posedge clk); #1;
    pixelValid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
    model_complete(model_sum(15, 15), 1'b0);
    checks++; if (lat != 2) begin failures++; $display("FAIL underflow_latency got=%0d want=2", lat); end
    checks++; if (fitness !== exp_fit || improved !== exp_imp) begin
      failures++; $display("FAIL underflow_fitness got=%0d/%b want=%0d/%b", fitness, improved, exp_fit, exp_imp);
    end
  endtask

  task automatic test_gapped_idle();
    int lat;
    int cnt0;
    logic [AW-1:0] held;
    for (int i = 0; i < 16; i++) begin mem[i] = 24'($urandom); frame_pix[i] = 24'($urandom); end
    run_frame(1'b1, 1'b1, 1'b0, lat);
    model_complete(model_sum(0, 15), 1'b0);
    checks++; if (lat != 2) begin failures++; $display("FAIL gapped_latency got=%0d want=2", lat); end
    checks++; if (fitness !== exp_fit || improved !== exp_imp || bestFitness !== exp_best) begin
      failures++; $display("FAIL gapped_fitness got=%0d/%b/%0d want=%0d/%b/%0d", fitness, improved, bestFitness, exp_fit, exp_imp, exp_best);
    end
    @(posedge clk); #1;
    held = exp_fit;
    cnt0 = done_cnt;
    for (int k = 0; k < 6; k++) begin
      pixelValid = 1'b1; pixel = 24'($urandom);
      pixelLine = (k % 2 == 0) ? '1 : H'($urandom); pixelColumn = (k % 2 == 0) ? '1 : W'($urandom);
      #1;
      checks++; if (targetRead !== 1'b0) begin failures++; $display("FAIL idle_targetRead got=%b want=0", targetRead); end
      @(posedge clk); #1;
    end
    pixelValid = 1'b0;
    checks++; if (fitness !== held || bestFitness !== exp_best || busy !== 1'b0 || done_cnt != cnt0) begin
      failures++; $display("FAIL idle_ignored got=%0d/%0d/%b/%0d want=%0d/%0d/0/%0d", fitness, bestFitness, busy, done_cnt, held, exp_best, cnt0);
    end
  endtask

  task automatic test_abort_start();
    int lat;
    int cnt0;
    for (int i = 0; i < 16; i++) begin mem[i] = 24'($urandom); frame_pix[i] = 24'($urandom); end
    cnt0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pixelValid = 1'b1; pixel = 24'($urandom); pixelLine = H'(i / 4); pixelColumn = W'(i % 4);
      @(posedge clk); #1;
    end
    start = 1'b1; pixelLine = '1; pixelColumn = '1;
    #1;
    checks++; if (targetRead !== 1'b0) begin failures++; $display("FAIL abort_targetRead got=%b want=0", targetRead); end
    @(posedge clk); #1;
    start = 1'b0; pixelValid = 1'b0;
    checks++; if (fitness !== '0 || busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL abort_clear got=%0d/%b/%b want=0/1/0", fitness, busy, done);
    end
    run_frame(1'b0, 1'b0, 1'b0, lat);
    model_complete(model_sum(0, 15), 1'b0);
    checks++; if (fitness !== exp_fit || improved !== exp_imp || bestFitness !== exp_best || lat != 2) begin
      failures++; $display("FAIL abort_next_frame got=%0d/%b/%0d lat=%0d want=%0d/%b/%0d lat=2", fitness, improved, bestFitness, lat, exp_fit, exp_imp, exp_best);
    end
    @(posedge clk); #1;
    checks++; if (done_cnt != cnt0 + 1) begin failures++; $display("FAIL abort_done_count got=%0d want=%0d", done_cnt - cnt0, 1); end
  endtask

  task automatic test_rst_midframe();
    int cnt0;
    cnt0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pixelValid = 1'b1; pixel = 24'($urandom); pixelLine = H'(i / 4); pixelColumn = W'(i % 4);
      @(posedge clk); #1;
    end
    pixelLine = '1; pixelColumn = '1;
    rst = 1'b1;
    #1;
    exp_best = ALL_ONES;
    checks++; if (fitness !== '0 || bestFitness !== ALL_ONES || {busy, done, improved, targetRead} !== 4'b0000) begin
      failures++; $display("FAIL rst_mid got=%0d/%h/%b want=0/%h/0000", fitness, bestFitness, {busy, done, improved, targetRead}, ALL_ONES);
    end
    @(posedge clk); #1;
    rst = 1'b0; pixelValid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (done_cnt != cnt0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_no_done got=%0d/%b want=%0d/0", done_cnt, busy, cnt0);
    end
  endtask

  task automatic test_clear_coincident();
    int lat;
    for (int i = 0; i < 16; i++) begin mem[i] = 24'($urandom); frame_pix[i] = mem[i]; end
    run_frame(1'b1, 1'b0, 1'b0, lat);
    model_complete(model_sum(0, 15), 1'b0);
    checks++; if (bestFitness !== exp_best) begin failures++; $display("FAIL clear_setup got=%0d want=%0d", bestFitness, exp_best); end
    for (int i = 0; i < 16; i++) frame_pix[i] = 24'($urandom);
    frame_pix[0] = ~mem[0];
    run_frame(1'b1, 1'b0, 1'b1, lat);
    model_complete(model_sum(0, 15), 1'b1);
    checks++; if (fitness !== exp_fit || improved !== exp_imp || bestFitness !== exp_best) begin
      failures++; $display("FAIL clear_coincident got=%0d/%b/%0d want=%0d/%b/%0d", fitness, improved, bestFitness, exp_fit, exp_imp, exp_best);
    end
    @(posedge clk); #1;
    clearBest = 1'b1;
    @(posedge clk); #1;
    clearBest = 1'b0;
    exp_best = ALL_ONES;
    checks++; if (bestFitness !== exp_best) begin failures++; $display("FAIL clear_idle got=%h want=%h", bestFitness, exp_best); end
  endtask

  task automatic test_random();
    int lat;
    bit gap;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) begin mem[i] = 24'($urandom); frame_pix[i] = 24'($urandom); end
      gap = 1'($urandom);
      run_frame(1'b1, gap, 1'b0, lat);
      model_complete(model_sum(0, 15), 1'b0);
      checks++; if (fitness !== exp_fit || improved !== exp_imp || bestFitness !== exp_best || lat != 2) begin
        failures++; $display("FAIL random_frame%0d got=%0d/%b/%0d lat=%0d want=%0d/%b/%0d lat=2", f, fitness, improved, bestFitness, lat, exp_fit, exp_imp, exp_best);
      end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || improved !== 1'b0) begin
        failures++; $display("FAIL random_pulse%0d got=%b%b want=00", f, done, improved);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pixelValid = 1'b0; pixel = '0;
    pixelLine = '0; pixelColumn = '0; clearBest = 1'b0;
    exp_best = ALL_ONES; exp_fit = '0; exp_imp = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_repeat();
    test_underflow();
    test_gapped_idle();
    test_abort_start();
    test_rst_midframe();
    test_clear_coincident();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
